// File: rtl/l3_cache_sched.sv
// l3_cache_sched: arbitrates the single-port l3_cache between the UART fill /
// world-update stream and renderer block reads.
// Optional feature macro: L3_SCHED_UPDATE_EN enables post-fill update packets
// (X, Y, Z, data) turning into single-block writes. Without it the cache is
// read-only once the initial fill completes and later rx bytes are discarded.
module l3_cache_sched #(
  parameter int LENGTH     = 64,
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 16,
  parameter int BLOCK_BITS = 8
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic [7:0]                                   rx_data_in,
  input  logic                                         rx_valid_in,
  input  logic                                         rd_req_in,
  input  logic [$clog2(LENGTH)-1:0]                    rd_x_in,
  input  logic [$clog2(WIDTH)-1:0]                     rd_y_in,
  input  logic [$clog2(HEIGHT)-1:0]                    rd_z_in,
  output logic                                         rd_ready_out,
  output logic                                         rd_valid_out,
  output logic [BLOCK_BITS-1:0]                        rd_data_out,
  output logic [$clog2(LENGTH)-1:0]                    cache_x_out,
  output logic [$clog2(WIDTH)-1:0]                     cache_y_out,
  output logic [$clog2(HEIGHT)-1:0]                    cache_z_out,
  output logic                                         cache_we_out,
  output logic                                         cache_re_out,
  output logic [BLOCK_BITS-1:0]                        cache_wdata_out,
  input  logic [BLOCK_BITS-1:0]                        cache_rdata_in,
  input  logic                                         cache_valid_in,
  output logic                                         initialized_out,
  output logic [$clog2(LENGTH*WIDTH*HEIGHT):0]         fill_count_out,
  output logic                                         overflow_out
);

  localparam int XW    = $clog2(LENGTH);
  localparam int YW    = $clog2(WIDTH);
  localparam int ZW    = $clog2(HEIGHT);
  localparam int TOTAL = LENGTH * WIDTH * HEIGHT;
  localparam int FCW   = $clog2(TOTAL) + 1;

`ifdef L3_SCHED_UPDATE_EN
  localparam bit UPDATE_EN = 1'b1;
`else
  localparam bit UPDATE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {FILL, IDLE, WRITE, READ_WAIT} state_t;

  state_t              state_reg, state_next;
  logic                hold_valid_reg, hold_valid_next;
  logic [7:0]          hold_data_reg, hold_data_next;
  logic [1:0]          pkt_idx_reg, pkt_idx_next;
  logic [XW-1:0]       wr_x_reg, wr_x_next;
  logic [YW-1:0]       wr_y_reg, wr_y_next;
  logic [ZW-1:0]       wr_z_reg, wr_z_next;
  logic [XW-1:0]       rd_x_reg, rd_x_next;
  logic [YW-1:0]       rd_y_reg, rd_y_next;
  logic [ZW-1:0]       rd_z_reg, rd_z_next;
  logic                cache_re_reg, cache_re_next;
  logic                rd_valid_reg, rd_valid_next;
  logic [BLOCK_BITS-1:0] rd_data_reg, rd_data_next;
  logic                initialized_reg, initialized_next;
  logic [FCW-1:0]      fill_count_reg, fill_count_next;
  logic                overflow_reg, overflow_next;

  logic                write_pending;
  logic                read_grant;
  logic [7:0]          byte_in;
  logic                hold_free;
  logic                rx_taken;
  logic                rx_accept;
  logic                absorb;
  logic                unused_byte_bits;

  // A held packet byte 3 is a write waiting for the cache; it blocks new reads.
  assign write_pending = UPDATE_EN && hold_valid_reg && (pkt_idx_reg == 2'd3);
  assign rd_ready_out  = (state_reg == IDLE) && initialized_reg && !write_pending;
  assign read_grant    = rd_req_in && rd_ready_out;
  // A byte already waiting in the holding register is older than a fresh rx byte.
  assign byte_in       = hold_valid_reg ? hold_data_reg : rx_data_in;
  assign unused_byte_bits = ^byte_in;

  // Next-state, arbitration, packet parsing and holding-register bookkeeping.
  always_comb begin
    state_next       = state_reg;
    hold_valid_next  = hold_valid_reg;
    hold_data_next   = hold_data_reg;
    pkt_idx_next     = pkt_idx_reg;
    wr_x_next        = wr_x_reg;
    wr_y_next        = wr_y_reg;
    wr_z_next        = wr_z_reg;
    rd_x_next        = rd_x_reg;
    rd_y_next        = rd_y_reg;
    rd_z_next        = rd_z_reg;
    cache_re_next    = 1'b0;
    rd_valid_next    = 1'b0;
    rd_data_next     = rd_data_reg;
    initialized_next = initialized_reg;
    fill_count_next  = fill_count_reg;
    overflow_next    = overflow_reg;
    hold_free        = !hold_valid_reg;
    rx_taken         = 1'b0;
    absorb           = 1'b0;

    case (state_reg)
      FILL: begin
        // The held byte is written this cycle at the raster address.
        if (hold_valid_reg) begin
          hold_free       = 1'b1;
          fill_count_next = fill_count_reg + FCW'(1);
          if (fill_count_reg == FCW'(TOTAL - 1)) begin
            initialized_next = 1'b1;
            state_next       = IDLE;
          end
        end
      end
      IDLE: begin
        if (write_pending) begin
          state_next = WRITE;
        end else begin
          // Coordinate bytes never touch the cache, so they are absorbed
          // alongside a read grant; only byte 3 competes for the cache.
          if (UPDATE_EN && hold_valid_reg) begin
            absorb    = 1'b1;
            hold_free = 1'b1;
          end else if (UPDATE_EN && rx_valid_in && !read_grant) begin
            if (pkt_idx_reg == 2'd3) begin
              state_next = WRITE;
            end else begin
              absorb   = 1'b1;
              rx_taken = 1'b1;
            end
          end
          if (read_grant) begin
            rd_x_next     = rd_x_in;
            rd_y_next     = rd_y_in;
            rd_z_next     = rd_z_in;
            cache_re_next = 1'b1;
            state_next    = READ_WAIT;
          end
        end
      end
      WRITE: begin
        hold_free    = 1'b1;
        pkt_idx_next = 2'd0;
        state_next   = IDLE;
      end
      READ_WAIT: begin
        if (cache_valid_in) begin
          rd_data_next  = cache_rdata_in;
          rd_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = FILL;
    endcase

    if (absorb) begin
      pkt_idx_next = pkt_idx_reg + 2'd1;
      case (pkt_idx_reg)
        2'd0:    wr_x_next = byte_in[XW-1:0];
        2'd1:    wr_y_next = byte_in[YW-1:0];
        default: wr_z_next = byte_in[ZW-1:0];
      endcase
    end

    // After the fill, a read-only build ignores the rx stream entirely.
    rx_accept = UPDATE_EN || ((state_reg == FILL) && !initialized_next);

    if (hold_valid_reg && hold_free) begin
      hold_valid_next = 1'b0;
    end
    if (rx_valid_in && rx_accept && !rx_taken) begin
      if (hold_free) begin
        hold_valid_next = 1'b1;
        hold_data_next  = rx_data_in;
      end else begin
        overflow_next = 1'b1;
      end
    end
  end

  // State and datapath registers; reset abandons any outstanding read.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg       <= FILL;
      hold_valid_reg  <= 1'b0;
      hold_data_reg   <= '0;
      pkt_idx_reg     <= '0;
      wr_x_reg        <= '0;
      wr_y_reg        <= '0;
      wr_z_reg        <= '0;
      rd_x_reg        <= '0;
      rd_y_reg        <= '0;
      rd_z_reg        <= '0;
      cache_re_reg    <= 1'b0;
      rd_valid_reg    <= 1'b0;
      rd_data_reg     <= '0;
      initialized_reg <= 1'b0;
      fill_count_reg  <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_valid_reg  <= hold_valid_next;
      hold_data_reg   <= hold_data_next;
      pkt_idx_reg     <= pkt_idx_next;
      wr_x_reg        <= wr_x_next;
      wr_y_reg        <= wr_y_next;
      wr_z_reg        <= wr_z_next;
      rd_x_reg        <= rd_x_next;
      rd_y_reg        <= rd_y_next;
      rd_z_reg        <= rd_z_next;
      cache_re_reg    <= cache_re_next;
      rd_valid_reg    <= rd_valid_next;
      rd_data_reg     <= rd_data_next;
      initialized_reg <= initialized_next;
      fill_count_reg  <= fill_count_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Cache address source follows whoever owns the port this cycle.
  always_comb begin
    cache_x_out = rd_x_reg;
    cache_y_out = rd_y_reg;
    cache_z_out = rd_z_reg;
    if (state_reg == FILL) begin
      cache_x_out = fill_count_reg[XW-1:0];
      cache_y_out = fill_count_reg[XW +: YW];
      cache_z_out = fill_count_reg[XW+YW +: ZW];
    end else if (state_reg == WRITE) begin
      cache_x_out = wr_x_reg;
      cache_y_out = wr_y_reg;
      cache_z_out = wr_z_reg;
    end
  end

  assign cache_we_out    = (state_reg == WRITE) || ((state_reg == FILL) && hold_valid_reg);
  assign cache_wdata_out = cache_we_out ? hold_data_reg[BLOCK_BITS-1:0] : '0;
  assign cache_re_out    = cache_re_reg;
  assign rd_valid_out    = rd_valid_reg;
  assign rd_data_out     = rd_data_reg;
  assign initialized_out = initialized_reg;
  assign fill_count_out  = fill_count_reg;
  assign overflow_out    = overflow_reg;

endmodule

// File: tb/tb_l3_cache_sched.sv
// Directed bench for l3_cache_sched on a reduced 8x16x4 volume so the full
// initial fill stays short; expectations follow the L3_SCHED_UPDATE_EN build.
module tb_l3_cache_sched;

  localparam int L = 8, W = 16, H = 4, BB = 8;
  localparam int XW = 3, YW = 4, ZW = 2, TOTAL = L * W * H, FCW = 10;

`ifdef L3_SCHED_UPDATE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [7:0]    rx_data_in;
  logic          rx_valid_in;
  logic          rd_req_in;
  logic [XW-1:0] rd_x_in;
  logic [YW-1:0] rd_y_in;
  logic [ZW-1:0] rd_z_in;
  logic          rd_ready_out;
  logic          rd_valid_out;
  logic [BB-1:0] rd_data_out;
  logic [XW-1:0] cache_x_out;
  logic [YW-1:0] cache_y_out;
  logic [ZW-1:0] cache_z_out;
  logic          cache_we_out;
  logic          cache_re_out;
  logic [BB-1:0] cache_wdata_out;
  logic [BB-1:0] cache_rdata_in;
  logic          cache_valid_in;
  logic          initialized_out;
  logic [FCW-1:0] fill_count_out;
  logic          overflow_out;

  int total = 0;
  int bad = 0;
  int we_count = 0;
  int re_count = 0;
  int rv_count = 0;
  int both_count = 0;
  int rv_before;
  int we_before;
  logic [7:0] pkt [4];

  always #5 clk_in = ~clk_in;

  l3_cache_sched #(.LENGTH(L), .WIDTH(W), .HEIGHT(H), .BLOCK_BITS(BB)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
    .rd_req_in(rd_req_in), .rd_x_in(rd_x_in), .rd_y_in(rd_y_in), .rd_z_in(rd_z_in),
    .rd_ready_out(rd_ready_out), .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
    .cache_x_out(cache_x_out), .cache_y_out(cache_y_out), .cache_z_out(cache_z_out),
    .cache_we_out(cache_we_out), .cache_re_out(cache_re_out),
    .cache_wdata_out(cache_wdata_out), .cache_rdata_in(cache_rdata_in),
    .cache_valid_in(cache_valid_in), .initialized_out(initialized_out),
    .fill_count_out(fill_count_out), .overflow_out(overflow_out)
  );

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (cache_we_out) we_count++;
    if (cache_re_out) re_count++;
    if (rd_valid_out) rv_count++;
    if (cache_we_out && cache_re_out) both_count++;
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_in = 1'b0; rx_data_in = '0; rx_valid_in = 1'b0; rd_req_in = 1'b0;
    rd_x_in = '0; rd_y_in = '0; rd_z_in = '0; cache_rdata_in = '0; cache_valid_in = 1'b0;
    step(); step();
    chk("reset_outputs", {rd_ready_out, rd_valid_out, rd_data_out, cache_x_out, cache_y_out,
        cache_z_out, cache_we_out, cache_re_out, cache_wdata_out, initialized_out,
        fill_count_out, overflow_out}, 64'd0);
    rst_in = 1'b1;
    step();

    // Read request before the fill completes must be ignored.
    rd_req_in = 1'b1; rd_x_in = 3'd1; rd_y_in = 4'd1; rd_z_in = 2'd1;
    step();
    chk("prefill_ready", rd_ready_out, 0);
    step();
    chk("prefill_no_re", re_count, 0);
    rd_req_in = 1'b0;

    // Initial fill in raster order, X fastest.
    for (int i = 0; i < TOTAL; i++) begin
      rx_valid_in = 1'b1; rx_data_in = 8'(i);
      step();
      rx_valid_in = 1'b0;
      chk("fill_write", {cache_we_out, cache_z_out, cache_y_out, cache_x_out, cache_wdata_out},
          {1'b1, 2'(i / (L * W)), 4'((i / L) % W), 3'(i % L), 8'(i)});
      step();
      chk("fill_after", {cache_we_out, initialized_out, fill_count_out},
          {1'b0, (i == TOTAL - 1), 10'(i + 1)});
    end
    chk("fill_done", {initialized_out, rd_ready_out, fill_count_out}, {1'b1, 1'b1, 10'd512});
    chk("fill_we_count", we_count, TOTAL);

    // Read (5,9,3); cache answers two cycles after the read strobe.
    rd_req_in = 1'b1; rd_x_in = 3'd5; rd_y_in = 4'd9; rd_z_in = 2'd3;
    step();
    rd_req_in = 1'b0;
    chk("read_issue", {cache_re_out, cache_z_out, cache_y_out, cache_x_out, rd_ready_out, rd_valid_out},
        {1'b1, 2'd3, 4'd9, 3'd5, 1'b0, 1'b0});
    step();
    chk("read_re_pulse", cache_re_out, 0);
    step();
    chk("read_not_yet", rd_valid_out, 0);
    cache_valid_in = 1'b1; cache_rdata_in = 8'h2A;
    step();
    cache_valid_in = 1'b0;
    chk("read_data", {rd_valid_out, rd_data_out, rd_ready_out}, {1'b1, 8'h2A, 1'b1});
    step();
    chk("read_hold", {rd_valid_out, rd_data_out}, {1'b0, 8'h2A});
    chk("read_re_count", re_count, 1);

    // Update packet with junk in the upper coordinate bits.
    pkt[0] = 8'h45; pkt[1] = 8'h09; pkt[2] = 8'hF3; pkt[3] = 8'h11;
    we_before = we_count;
    for (int b = 0; b < 4; b++) begin
      rx_valid_in = 1'b1; rx_data_in = pkt[b];
      step();
      rx_valid_in = 1'b0;
      if (b < 3) begin
        chk("pkt_no_write", cache_we_out, 0);
      end else begin
        chk("pkt_write", {cache_we_out, cache_wdata_out}, EN ? {1'b1, 8'h11} : {1'b0, 8'h00});
        chk("pkt_addr", {cache_z_out, cache_y_out, cache_x_out}, {2'd3, 4'd9, 3'd5});
        chk("pkt_ready", rd_ready_out, !EN);
      end
      step();
    end
    chk("pkt_we_count", we_count, we_before + (EN ? 1 : 0));

    // Packet byte 3 lands during READ_WAIT; write follows rd_valid.
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
    for (int b = 0; b < 3; b++) begin
      rx_valid_in = 1'b1; rx_data_in = pkt[b];
      step();
      rx_valid_in = 1'b0;
      step();
    end
    rd_req_in = 1'b1; rd_x_in = 3'd2; rd_y_in = 4'd3; rd_z_in = 2'd1;
    step();
    rd_req_in = 1'b0;
    chk("rw_read_issue", cache_re_out, 1);
    rx_valid_in = 1'b1; rx_data_in = 8'h77;
    step();
    rx_valid_in = 1'b0;
    step();
    cache_valid_in = 1'b1; cache_rdata_in = 8'h5C;
    step();
    cache_valid_in = 1'b0;
    chk("rw_read_first", {rd_valid_out, rd_data_out, cache_we_out}, {1'b1, 8'h5C, 1'b0});
    step();
    chk("rw_write_after", {cache_we_out, cache_z_out, cache_y_out, cache_x_out, cache_wdata_out},
        EN ? {1'b1, 2'd3, 4'd2, 3'd1, 8'h77} : {1'b0, 2'd1, 4'd3, 3'd2, 8'h00});
    chk("rw_no_overflow", overflow_out, 0);
    step();
    chk("rw_we_count", we_count, we_before + (EN ? 2 : 0));

    // Two rx bytes in consecutive cycles during READ_WAIT.
    rd_req_in = 1'b1; rd_x_in = 3'd4; rd_y_in = 4'd4; rd_z_in = 2'd2;
    step();
    rd_req_in = 1'b0;
    rx_valid_in = 1'b1; rx_data_in = 8'hA1;
    step();
    rx_data_in = 8'hB2;
    step();
    rx_valid_in = 1'b0;
    chk("ovf_set", overflow_out, EN);
    cache_valid_in = 1'b1; cache_rdata_in = 8'h33;
    step();
    cache_valid_in = 1'b0;
    chk("ovf_read_data", {rd_valid_out, rd_data_out}, {1'b1, 8'h33});
    for (int k = 0; k < 5; k++) step();
    chk("ovf_sticky", overflow_out, EN);
    chk("ovf_no_extra_write", we_count, we_before + (EN ? 2 : 0));

    // Reset pulse in the middle of READ_WAIT.
    rd_req_in = 1'b1; rd_x_in = 3'd6; rd_y_in = 4'd6; rd_z_in = 2'd1;
    step();
    rd_req_in = 1'b0;
    step();
    rv_before = rv_count;
    rst_in = 1'b0;
    #1;
    chk("rst_outputs", {rd_ready_out, rd_valid_out, rd_data_out, cache_x_out, cache_y_out,
        cache_z_out, cache_we_out, cache_re_out, cache_wdata_out, initialized_out,
        fill_count_out, overflow_out}, 64'd0);
    step();
    rst_in = 1'b1;
    cache_valid_in = 1'b1; cache_rdata_in = 8'h99;
    step();
    cache_valid_in = 1'b0;
    step(); step();
    chk("rst_no_rd_valid", {rd_valid_out, rd_data_out, rd_ready_out}, 64'd0);
    chk("rst_rv_count", rv_count, rv_before);
    rx_valid_in = 1'b1; rx_data_in = 8'h5A;
    step();
    rx_valid_in = 1'b0;
    chk("rst_fill_restart", {cache_we_out, cache_z_out, cache_y_out, cache_x_out, cache_wdata_out,
        initialized_out, overflow_out}, {1'b1, 2'd0, 4'd0, 3'd0, 8'h5A, 1'b0, 1'b0});
    step();
    chk("rst_fill_count", fill_count_out, 1);
    chk("no_we_re_overlap", both_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
